// File: rtl/e203_exu_alu_muldiv_srv.sv
// e203_exu_alu_muldiv_srv: muldiv shared-resource responder (shared adder, shared buffers, burst/error tracking)
// Ports: muldiv_req_alu_* adder request/result from muldiv; muldiv_sbf_{0,1}_* shared buffer load/readback;
//        alu_req_alu_* plain ALU adder request/grant/result; mdv_req_cnt burst length; err_clr/proto_err sticky error.
module e203_exu_alu_muldiv_srv #(
    parameter int ADDER_W = 35,
    parameter int SBF_W   = 33,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               muldiv_req_alu,
    input  logic [ADDER_W-1:0] muldiv_req_alu_op1,
    input  logic [ADDER_W-1:0] muldiv_req_alu_op2,
    input  logic               muldiv_req_alu_add,
    input  logic               muldiv_req_alu_sub,
    output logic [ADDER_W-1:0] muldiv_req_alu_res,
    input  logic               muldiv_sbf_0_ena,
    input  logic [SBF_W-1:0]   muldiv_sbf_0_nxt,
    input  logic               muldiv_sbf_1_ena,
    input  logic [SBF_W-1:0]   muldiv_sbf_1_nxt,
    output logic [SBF_W-1:0]   muldiv_sbf_0_r,
    output logic [SBF_W-1:0]   muldiv_sbf_1_r,
    input  logic               alu_req_alu,
    input  logic [XLEN-1:0]    alu_req_alu_op1,
    input  logic [XLEN-1:0]    alu_req_alu_op2,
    input  logic               alu_req_alu_add,
    input  logic               alu_req_alu_sub,
    output logic               alu_gnt,
    output logic [XLEN-1:0]    alu_req_alu_res,
    output logic [CNT_W-1:0]   mdv_req_cnt,
    input  logic               err_clr,
    output logic               proto_err
);
    logic [ADDER_W-1:0] op1, op2, res;
    logic               add, sub;
    assign alu_gnt = alu_req_alu & ~muldiv_req_alu;
    always_comb begin
        op1 = muldiv_req_alu ? muldiv_req_alu_op1 : alu_gnt ? ADDER_W'(alu_req_alu_op1) : '0;
        op2 = muldiv_req_alu ? muldiv_req_alu_op2 : alu_gnt ? ADDER_W'(alu_req_alu_op2) : '0;
        add = muldiv_req_alu ? muldiv_req_alu_add : alu_gnt & alu_req_alu_add;
        sub = muldiv_req_alu ? muldiv_req_alu_sub : alu_gnt & alu_req_alu_sub;
        // add wins when both selects are set
        res = add ? op1 + op2 : sub ? op1 + ~op2 + ADDER_W'(1) : '0;
    end
    assign muldiv_req_alu_res = muldiv_req_alu ? res : '0;
    assign alu_req_alu_res    = alu_gnt ? res[XLEN-1:0] : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            muldiv_sbf_0_r <= '0;
            muldiv_sbf_1_r <= '0;
            mdv_req_cnt    <= '0;
            proto_err      <= 1'b0;
        end else begin
            if (muldiv_sbf_0_ena) muldiv_sbf_0_r <= muldiv_sbf_0_nxt;
            if (muldiv_sbf_1_ena) muldiv_sbf_1_r <= muldiv_sbf_1_nxt;
            mdv_req_cnt <= muldiv_req_alu ? (&mdv_req_cnt ? mdv_req_cnt : mdv_req_cnt + 1'b1) : '0;
            // setting outranks a same-cycle clear
            proto_err   <= (muldiv_req_alu & (muldiv_req_alu_add == muldiv_req_alu_sub)) | (proto_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_e203_exu_alu_muldiv_srv.sv
// tb_e203_exu_alu_muldiv_srv: scoreboard bench for the muldiv shared-resource responder
module tb_e203_exu_alu_muldiv_srv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mreq = 1'b0, madd = 1'b0, msub = 1'b0;
    logic [34:0] mop1 = '0, mop2 = '0, mres;
    logic        s0_ena = 1'b0, s1_ena = 1'b0;
    logic [32:0] s0_nxt = '0, s1_nxt = '0, s0_r, s1_r;
    logic        areq = 1'b0, aadd = 1'b0, asub = 1'b0, gnt;
    logic [31:0] aop1 = '0, aop2 = '0, ares;
    logic [5:0]  cnt;
    logic        err_clr = 1'b0, perr;
    int          n_chk = 0, n_err = 0;

    typedef struct {
        bit          comb;
        logic [34:0] mres;
        logic [31:0] ares;
        logic        gnt;
        logic [32:0] s0, s1;
        logic [5:0]  cnt;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [32:0] m_s0 = '0, m_s1 = '0;
    logic [5:0]  m_cnt = '0;
    logic        m_err = 1'b0;

    e203_exu_alu_muldiv_srv dut (
        .clk(clk), .rst(rst),
        .muldiv_req_alu(mreq), .muldiv_req_alu_op1(mop1), .muldiv_req_alu_op2(mop2),
        .muldiv_req_alu_add(madd), .muldiv_req_alu_sub(msub), .muldiv_req_alu_res(mres),
        .muldiv_sbf_0_ena(s0_ena), .muldiv_sbf_0_nxt(s0_nxt),
        .muldiv_sbf_1_ena(s1_ena), .muldiv_sbf_1_nxt(s1_nxt),
        .muldiv_sbf_0_r(s0_r), .muldiv_sbf_1_r(s1_r),
        .alu_req_alu(areq), .alu_req_alu_op1(aop1), .alu_req_alu_op2(aop2),
        .alu_req_alu_add(aadd), .alu_req_alu_sub(asub), .alu_gnt(gnt), .alu_req_alu_res(ares),
        .mdv_req_cnt(cnt), .err_clr(err_clr), .proto_err(perr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        check("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.comb) begin
            check("mres", 64'(mres), 64'(e.mres));
            check("ares", 64'(ares), 64'(e.ares));
            check("gnt", 64'(gnt), 64'(e.gnt));
        end else begin
            check("sbf0", 64'(s0_r), 64'(e.s0));
            check("sbf1", 64'(s1_r), 64'(e.s1));
            check("cnt", 64'(cnt), 64'(e.cnt));
            check("perr", 64'(perr), 64'(e.err));
        end
    endtask

    // One clock: inputs already driven after a negedge; ends on the next negedge.
    task automatic cyc();
        exp_t e;
        logic [34:0] r;
        e = '{default: '0};
        e.comb = 1'b1;
        if (mreq) begin
            e.mres = madd ? mop1 + mop2 : msub ? mop1 - mop2 : 35'd0;
        end else if (areq) begin
            r = aadd ? {3'b0, aop1} + {3'b0, aop2} : asub ? {3'b0, aop1} - {3'b0, aop2} : 35'd0;
            e.ares = r[31:0];
            e.gnt  = 1'b1;
        end
        sb.push_back(e);
        #1 pop_check();
        if (s0_ena) m_s0 = s0_nxt;
        if (s1_ena) m_s1 = s1_nxt;
        m_cnt = !mreq ? 6'd0 : (m_cnt == 6'd63) ? 6'd63 : m_cnt + 6'd1;
        m_err = (mreq && madd == msub) ? 1'b1 : err_clr ? 1'b0 : m_err;
        e = '{default: '0};
        e.s0 = m_s0; e.s1 = m_s1; e.cnt = m_cnt; e.err = m_err;
        sb.push_back(e);
        @(posedge clk) #1 pop_check();
        @(negedge clk);
    endtask

    task automatic mdv(input logic [34:0] a, input logic [34:0] b, input logic ad, input logic su);
        mreq = 1'b1; mop1 = a; mop2 = b; madd = ad; msub = su;
        cyc();
    endtask

    initial begin
        @(negedge clk);
        check("rst_sbf0", 64'(s0_r), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        check("rst_perr", 64'(perr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        // load then async reset between edges
        s0_ena = 1'b1; s0_nxt = 33'h1_2345_6789;
        mdv(35'd1, 35'd1, 1'b1, 1'b0);
        s0_ena = 1'b0; mreq = 1'b0;
        check("pre_rst_sbf0", 64'(s0_r), 64'h1_2345_6789);
        rst = 1'b1;
        #1;
        check("mid_rst_sbf0", 64'(s0_r), 64'd0);
        check("mid_rst_cnt", 64'(cnt), 64'd0);
        check("mid_rst_perr", 64'(perr), 64'd0);
        #1 rst = 1'b0;
        m_s0 = '0; m_s1 = '0; m_cnt = '0; m_err = 1'b0;
        @(negedge clk);
        // muldiv add/sub
        mdv(35'd5, 35'd3, 1'b1, 1'b0);
        mdv(35'd5, 35'd3, 1'b0, 1'b1);
        mdv(35'd3, 35'd5, 1'b0, 1'b1);
        mdv(35'h7_FFFF_FFFF, 35'd1, 1'b1, 1'b0);
        // arbitration
        mreq = 1'b0; madd = 1'b0; msub = 1'b0;
        areq = 1'b1; aop1 = 32'hFFFF_FFFF; aop2 = 32'd1; aadd = 1'b1;
        cyc();
        mdv(35'd7, 35'd2, 1'b1, 1'b0);
        mreq = 1'b0;
        aadd = 1'b0; asub = 1'b1; aop1 = 32'd1; aop2 = 32'd2;
        cyc();
        asub = 1'b0;
        cyc();
        areq = 1'b0;
        // buffers: dual load then hold with changing data
        s0_ena = 1'b1; s1_ena = 1'b1; s0_nxt = 33'h1_AAAA_AAAA; s1_nxt = 33'h0_5555_5555;
        cyc();
        s0_ena = 1'b0; s1_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s0_nxt = 33'($urandom); s1_nxt = {1'b1, 32'($urandom)};
            cyc();
        end
        s1_ena = 1'b1; s1_nxt = 33'h1_0F0F_0F0F;
        mdv(35'd9, 35'd4, 1'b1, 1'b0);
        s1_ena = 1'b0;
        // burst counter saturation
        for (int i = 0; i < 70; i++) mdv(35'(i), 35'd1, 1'b1, 1'b0);
        mreq = 1'b0;
        cyc();
        mdv(35'd1, 35'd1, 1'b1, 1'b0);
        // protocol error
        mdv(35'd10, 35'd6, 1'b1, 1'b1);
        err_clr = 1'b1;
        mdv(35'd10, 35'd6, 1'b0, 1'b0);
        mreq = 1'b0;
        cyc();
        err_clr = 1'b0;
        cyc();
        areq = 1'b1; aadd = 1'b1; asub = 1'b1;
        cyc();
        areq = 1'b0;
        // random traffic
        for (int i = 0; i < 200; i++) begin
            mreq = 1'($urandom); madd = 1'($urandom); msub = 1'($urandom);
            mop1 = {3'($urandom), 32'($urandom)}; mop2 = {3'($urandom), 32'($urandom)};
            areq = 1'($urandom); aadd = 1'($urandom); asub = 1'($urandom);
            aop1 = $urandom; aop2 = $urandom;
            s0_ena = 1'($urandom); s1_ena = 1'($urandom);
            s0_nxt = {1'($urandom), 32'($urandom)}; s1_nxt = {1'($urandom), 32'($urandom)};
            err_clr = ($urandom_range(0, 3) == 0);
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/e203_exu_alu_muldiv_srv.md
Name: e203_exu_alu_muldiv_srv

Overview:
- Responder side of the muldiv shared-resource interface.
- Owns the shared 35-bit adder and the two 33-bit shared buffers (sbf_0/sbf_1) that e203_exu_alu_muldiv drives via request/enable strobes.
- Arbitrates the adder between muldiv and the plain ALU path, and tracks request-burst length and protocol errors.
- Sits in the ALU datapath next to e203_exu_alu_muldiv.

Parameters:
- ADDER_W, 35, shared adder width (matches E203_MULDIV_ADDER_WIDTH)
- SBF_W, 33, shared buffer width
- XLEN, 32, plain ALU operand width
- CNT_W, 6, burst counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- muldiv_req_alu  in  1  muldiv requests adder this cycle
- muldiv_req_alu_op1  in  ADDER_W  muldiv operand 1
- muldiv_req_alu_op2  in  ADDER_W  muldiv operand 2
- muldiv_req_alu_add  in  1  add select
- muldiv_req_alu_sub  in  1  subtract select
- muldiv_req_alu_res  out  ADDER_W  adder result to muldiv
- muldiv_sbf_0_ena  in  1  load strobe, buffer 0
- muldiv_sbf_0_nxt  in  SBF_W  load data, buffer 0
- muldiv_sbf_1_ena  in  1  load strobe, buffer 1
- muldiv_sbf_1_nxt  in  SBF_W  load data, buffer 1
- muldiv_sbf_0_r  out  SBF_W  buffer 0 register
- muldiv_sbf_1_r  out  SBF_W  buffer 1 register
- alu_req_alu  in  1  plain ALU requests adder
- alu_req_alu_op1  in  XLEN  ALU operand 1
- alu_req_alu_op2  in  XLEN  ALU operand 2
- alu_req_alu_add  in  1  ALU add select
- alu_req_alu_sub  in  1  ALU subtract select
- alu_gnt  out  1  ALU granted adder this cycle
- alu_req_alu_res  out  XLEN  ALU result
- mdv_req_cnt  out  CNT_W  consecutive muldiv request cycles
- err_clr  in  1  clear sticky error
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): sbf_0_r=0, sbf_1_r=0, mdv_req_cnt=0, proto_err=0. Combinational outputs follow their rules with the inputs present.

Arbitration (combinational):
- Muldiv has absolute priority.
- alu_gnt = alu_req_alu & ~muldiv_req_alu.
- Operand select:
  - muldiv_req_alu=1: muldiv op1/op2 and muldiv add/sub.
  - else if alu_gnt: ALU operands zero-extended to ADDER_W, with ALU add/sub.
  - else: operands 0.

Adder (combinational, same-cycle result, wraps mod 2^ADDER_W):
- add=1: res = op1 + op2.
- add=0, sub=1: res = op1 + ~op2 + 1.
- Neither set: res = 0.
- add and sub both set: add wins.
- muldiv_req_alu_res = res when muldiv_req_alu, else 0.
- alu_req_alu_res = res[XLEN-1:0] when alu_gnt, else 0.

Shared buffers (registered):
- On a rising edge with sbf_N_ena=1: sbf_N_r <= sbf_N_nxt. Otherwise hold.
- The two buffers are independent; simultaneous loads both take effect.
- Data from a load is visible one cycle after the enable edge.
- A load in the same cycle as an adder request is legal.

Burst counter:
- muldiv_req_alu=1 at edge: mdv_req_cnt <= min(cnt+1, 2^CNT_W-1); saturates at 63 and holds.
- muldiv_req_alu=0 at edge: mdv_req_cnt <= 0.

Protocol error (sticky):
- Set condition at edge: muldiv_req_alu & (add == sub), i.e. both or neither selected.
- Set has priority over err_clr in the same cycle.
- err_clr=1 alone clears to 0 next edge.
- Cleared only by err_clr or reset.
- ALU-side errors are not flagged.

Reset mid-operation:
- Buffers and counter go to 0 immediately (async).
- Outputs are valid again from the first edge after rst deasserts.

Test Plan:
- Reset: drive sbf_0_ena=1, nxt=0x1_2345_6789 for 1 cycle, then assert rst between edges → sbf_0_r reads 0 immediately, proto_err=0, mdv_req_cnt=0.
- Muldiv add/sub: op1=5, op2=3, add → res=0x0_0000_0008. Same operands with sub → res=0x0_0000_0002. op1=3, op2=5, sub → res=0x7_FFFF_FFFE.
- Arbitration: alu_req_alu=1, op1=0xFFFF_FFFF, op2=1, add, muldiv_req_alu=0 → alu_gnt=1, alu_res=0x0000_0000. Same cycle with muldiv_req_alu=1 → alu_gnt=0, alu_res=0.
- Buffers: sbf_0_ena and sbf_1_ena both set, nxt=0x1_AAAA_AAAA / 0x0_5555_5555 → both registers update next cycle. With enables low for 3 cycles and nxt changing → values hold.
- Counter: muldiv_req_alu high for 70 cycles → mdv_req_cnt reaches 63 and stays. One low cycle → 0. High again → 1.
- Error: muldiv_req_alu=1 with add=sub=1 → res=op1+op2, proto_err=1 next cycle. Set condition and err_clr together → stays 1. err_clr alone → 0 next cycle.
